// File: rtl/in_sync_pkg.sv
// in_sync_pkg: shared pulse-mode constants and clog2 helper for in_sync_debounce.
// Contents: MODE_RISE/MODE_FALL/MODE_BOTH pulse edge selectors, clog2(v) counter sizing.
package in_sync_pkg;
    localparam int MODE_RISE = 0;
    localparam int MODE_FALL = 1;
    localparam int MODE_BOTH = 2;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/in_sync_ch.sv
// in_sync_ch: one channel of synchronizer chain, debounce counter, level and edge pulse.
// Ports: clk, rst (async high) | in_i raw async input | level_o debounced level | pulse_o edge pulse.
module in_sync_ch
    import in_sync_pkg::*;
#(
    parameter int STAGES = 2,
    parameter int DB_CNT = 4,
    parameter int MODE   = MODE_RISE
) (
    input  logic clk,
    input  logic rst,
    input  logic in_i,
    output logic level_o,
    output logic pulse_o
);
    localparam int CW = clog2(DB_CNT + 1);
    logic [STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              level_q, level_d, pulse_q, pulse_d;
    logic              s, diff, done;
    assign s    = sync_q[STAGES-1];
    assign diff = s != level_q;
    // A change is accepted only after DB_CNT consecutive disagreeing samples;
    // any agreeing sample in between zeroes the count.
    assign done = diff && cnt_q == CW'(DB_CNT - 1);
    always_comb begin
        sync_d  = {sync_q[STAGES-2:0], in_i};
        cnt_d   = (!diff || done) ? '0 : cnt_q + CW'(1);
        level_d = done ? s : level_q;
        pulse_d = done && (MODE == MODE_BOTH || (MODE == MODE_RISE ? s : !s));
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
        end
    end
    assign level_o = level_q;
    assign pulse_o = pulse_q;
endmodule

// File: rtl/in_sync_debounce.sv
// in_sync_debounce: N independent synchronize-and-debounce channels with edge pulses.
// Ports: clk, rst (async high) | in[N] raw async inputs | level[N] debounced levels | pulse[N] edge pulses.
module in_sync_debounce
    import in_sync_pkg::*;
#(
    parameter int N      = 4,
    parameter int STAGES = 2,
    parameter int DB_CNT = 4,
    parameter int MODE   = MODE_RISE
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] in,
    output logic [N-1:0] level,
    output logic [N-1:0] pulse
);
    for (genvar i = 0; i < N; i++) begin : g_ch
        in_sync_ch #(
            .STAGES(STAGES),
            .DB_CNT(DB_CNT),
            .MODE  (MODE)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .in_i   (in[i]),
            .level_o(level[i]),
            .pulse_o(pulse[i])
        );
    end
endmodule

// File: tb/tb_in_sync_debounce.sv
// tb_in_sync_debounce: scoreboard bench driving a rise-mode and a fall-mode instance in parallel.
module tb_in_sync_debounce;
    import in_sync_pkg::*;
    typedef struct {
        string      nm;
        logic [3:0] lv;
        logic [3:0] p0;
        logic [3:0] p1;
        logic [3:0] m;
    } exp_t;
    logic       clk = 1'b0;
    logic       clk_en = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] in_r = 4'b1111;
    logic [3:0] level0, pulse0, level1, pulse1;
    exp_t       q[$];
    event       sample_ev;
    int         errors = 0;
    int         checks = 0;
    in_sync_debounce #(.N(4), .STAGES(2), .DB_CNT(4), .MODE(MODE_RISE)) dut0 (
        .clk(clk), .rst(rst), .in(in_r), .level(level0), .pulse(pulse0)
    );
    in_sync_debounce #(.N(4), .STAGES(2), .DB_CNT(4), .MODE(MODE_FALL)) dut1 (
        .clk(clk), .rst(rst), .in(in_r), .level(level1), .pulse(pulse1)
    );
    initial begin
        wait (clk_en);
        forever #10 clk = ~clk;
    end
    initial forever begin
        @(posedge clk);
        #5;
        ->sample_ev;
    end
    function automatic void chk(string nm, string f, logic [3:0] got, logic [3:0] exp, logic [3:0] m);
        checks++;
        if ((got & m) !== (exp & m)) begin
            errors++;
            $display("FAIL %s %s: got %b expected %b (mask %b) at %0t", nm, f, got, exp, m, $time);
        end
    endfunction
    initial forever begin
        @(sample_ev);
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            chk(e.nm, "level_rise_mode", level0, e.lv, e.m);
            chk(e.nm, "level_fall_mode", level1, e.lv, e.m);
            chk(e.nm, "pulse_rise_mode", pulse0, e.p0, e.m);
            chk(e.nm, "pulse_fall_mode", pulse1, e.p1, e.m);
        end
    end
    task automatic cyc(input logic [3:0] nin, input logic [3:0] lv, input logic [3:0] p0,
                       input logic [3:0] p1, input logic [3:0] m, input string nm);
        in_r = nin;
        q.push_back('{nm, lv, p0, p1, m});
        @(negedge clk);
    endtask
    initial begin
        #1 rst = 1'b1;
        #4;
        q.push_back('{"reset_no_clk", 4'b0000, 4'b0000, 4'b0000, 4'b1111});
        ->sample_ev;
        #1;
        in_r = 4'b0000;
        clk_en = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 8; k++)
            cyc(4'b0001, k >= 6 ? 4'b0001 : 4'b0000, k == 6 ? 4'b0001 : 4'b0000, 4'b0000, 4'b0001, "rise0");
        repeat (3) cyc(4'b0011, 4'b0001, 4'b0000, 4'b0000, 4'b0011, "glitch1_high");
        repeat (8) cyc(4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0011, "glitch1_low");
        for (int k = 1; k <= 30; k++)
            cyc(k <= 20 ? ((((k - 1) / 2) % 2 == 0) ? 4'b0101 : 4'b0001) : 4'b0101,
                k >= 26 ? 4'b0101 : 4'b0001, k == 26 ? 4'b0100 : 4'b0000, 4'b0000, 4'b0111, "bounce2");
        for (int k = 1; k <= 8; k++)
            cyc(4'b1101, k >= 6 ? 4'b1000 : 4'b0000, k == 6 ? 4'b1000 : 4'b0000, 4'b0000, 4'b1000, "rise3");
        for (int k = 1; k <= 8; k++)
            cyc(4'b0101, k >= 6 ? 4'b0000 : 4'b1000, 4'b0000, k == 6 ? 4'b1000 : 4'b0000, 4'b1000, "fall3");
        for (int k = 1; k <= 8; k++)
            cyc(4'b0100, k < 6 ? 4'b0101 : 4'b0100, 4'b0000, k == 6 ? 4'b0001 : 4'b0000, 4'b0101, "fall0");
        repeat (4) cyc(4'b0101, 4'b0100, 4'b0000, 4'b0000, 4'b0101, "count0");
        rst = 1'b1;
        #1;
        q.push_back('{"rst_mid", 4'b0000, 4'b0000, 4'b0000, 4'b1111});
        ->sample_ev;
        repeat (2) cyc(4'b0101, 4'b0000, 4'b0000, 4'b0000, 4'b1111, "rst_hold");
        rst = 1'b0;
        for (int k = 1; k <= 8; k++)
            cyc(4'b0101, k >= 6 ? 4'b0101 : 4'b0000, k == 6 ? 4'b0101 : 4'b0000, 4'b0000, 4'b1111, "requal");
        repeat (4) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
